snake_segments: RTL and testbench

- Upstream stage of the collision/scoring logic: owns the snake's segment positions on a cell grid.
- Steps the snake one cell per move tick, applies direction changes and growth requests.
- For every VGA pixel, produces registered snake_head / snake_body hit flags that the collision stage consumes.
- Reports snake length, head cell and self-hit status.

---
 rtl/snake_pkg.sv | 18 +
 rtl/snake_dir_ctrl.sv | 35 +++
 rtl/snake_segments.sv | 125 ++++++++++++
 tb/tb_snake_segments.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared direction/state types, segment record and initial placement helper.
package snake_pkg;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;
  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
  } seg_t;
  localparam int INIT_HEAD_X = 20;
  localparam int INIT_HEAD_Y = 15;
  // Body trails left of the head; slots beyond the initial length reuse the tail cell.
  function automatic seg_t init_seg(input int i, input int init_len);
    seg_t s;
    s.x = 6'(INIT_HEAD_X - ((i < init_len) ? i : init_len - 1));
    s.y = 5'(INIT_HEAD_Y);
    return s;
  endfunction
endpackage

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: button priority, reversal filter and pending/current direction registers.
module snake_dir_ctrl
  import snake_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  input  logic i_move,
  input  logic i_up,
  input  logic i_down,
  input  logic i_left,
  input  logic i_right,
  output dir_t o_pending_dir
);
  dir_t r_dir, r_pending, w_req;
  logic w_any, w_rev;
  always_comb begin
    w_any = i_up | i_down | i_left | i_right;
    w_req = i_up ? UP : i_down ? DOWN : i_left ? LEFT : RIGHT;
    w_rev = (w_req ^ 2'b01) == r_dir;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir     <= RIGHT;
      r_pending <= RIGHT;
    end else if (i_restart) begin
      r_dir     <= RIGHT;
      r_pending <= RIGHT;
    end else begin
      if (i_move) r_dir <= r_pending;
      if (w_any && !w_rev) r_pending <= w_req;
    end
  end
  assign o_pending_dir = r_pending;
endmodule

// File: rtl/snake_segments.sv
// snake_segments: segment store, movement FSM and registered per-pixel head/body flags.
// Define SNAKE_WRAP_EN to wrap the head around grid edges instead of freezing.
module snake_segments
  import snake_pkg::*;
#(
  parameter int CELL_PX  = 16,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        move_tick,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        grow,
  input  logic        freeze,
  input  logic        restart,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_col,
  output logic        snake_head,
  output logic        snake_body,
  output logic [5:0]  snake_length,
  output logic [5:0]  head_x,
  output logic [4:0]  head_y,
  output logic        self_hit,
  output logic        out_of_bounds
);
  localparam int SH = $clog2(CELL_PX);
  state_t r_state, w_state_nx;
  seg_t r_seg [MAX_LEN];
  seg_t w_head_nx;
  dir_t w_dir;
  logic [5:0] r_len;
  logic [11:0] w_cx, w_cy;
  logic r_grow_pend, r_moved, r_self_hit, r_oob, r_head, r_body;
  logic w_any, w_move, w_go, w_edge_hit, w_hit, w_hit_set, w_in, w_pix_head, w_pix_body;

  snake_dir_ctrl u_dir (
    .i_clk(vga_clk), .i_rst_n(reset), .i_restart(restart), .i_move(w_move),
    .i_up(up), .i_down(down), .i_left(left), .i_right(right), .o_pending_dir(w_dir)
  );

  // The step uses the direction being committed on this tick.
  always_comb begin
    w_any = up | down | left | right;
    w_move = r_state == RUN && move_tick && !restart;
    w_head_nx = r_seg[0];
`ifdef SNAKE_WRAP_EN
    w_head_nx.x = w_dir == RIGHT ? (r_seg[0].x == 6'(GRID_W - 1) ? 6'd0 : r_seg[0].x + 6'd1) :
                  w_dir == LEFT  ? (r_seg[0].x == 6'd0 ? 6'(GRID_W - 1) : r_seg[0].x - 6'd1) : r_seg[0].x;
    w_head_nx.y = w_dir == DOWN  ? (r_seg[0].y == 5'(GRID_H - 1) ? 5'd0 : r_seg[0].y + 5'd1) :
                  w_dir == UP    ? (r_seg[0].y == 5'd0 ? 5'(GRID_H - 1) : r_seg[0].y - 5'd1) : r_seg[0].y;
    w_edge_hit = 1'b0;
`else
    w_head_nx.x = w_dir == RIGHT ? r_seg[0].x + 6'd1 : w_dir == LEFT ? r_seg[0].x - 6'd1 : r_seg[0].x;
    w_head_nx.y = w_dir == DOWN ? r_seg[0].y + 5'd1 : w_dir == UP ? r_seg[0].y - 5'd1 : r_seg[0].y;
    w_edge_hit = w_move && ((w_dir == RIGHT && r_seg[0].x == 6'(GRID_W - 1)) ||
                            (w_dir == LEFT && r_seg[0].x == 6'd0) ||
                            (w_dir == UP && r_seg[0].y == 5'd0) ||
                            (w_dir == DOWN && r_seg[0].y == 5'(GRID_H - 1)));
`endif
    w_go = w_move && !w_edge_hit;
    w_cx = pixel_col >> SH;
    w_cy = pixel_row >> SH;
    w_in = pixel_col < 12'(GRID_W * CELL_PX) && pixel_row < 12'(GRID_H * CELL_PX);
    w_pix_head = w_in && w_cx == {6'b0, r_seg[0].x} && w_cy == {7'b0, r_seg[0].y};
    w_hit = 1'b0;
    w_pix_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (6'(i) < r_len && r_seg[i] == r_seg[0]) w_hit = 1'b1;
      if (6'(i) < r_len && w_cx == {6'b0, r_seg[i].x} && w_cy == {7'b0, r_seg[i].y}) w_pix_body = 1'b1;
    end
    w_pix_body = w_in && w_pix_body && !w_pix_head;
    w_hit_set = r_moved && w_hit;
  end

  always_comb begin
    w_state_nx = restart ? IDLE :
                 r_state == IDLE ? (freeze ? FROZEN : w_any ? RUN : IDLE) :
                 r_state == RUN ? ((freeze | w_edge_hit | w_hit_set | r_self_hit | r_oob) ? FROZEN : RUN) :
                 r_state;
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_state_nx;
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset || restart) begin
      for (int i = 0; i < MAX_LEN; i++) r_seg[i] <= init_seg(i, INIT_LEN);
      r_len       <= 6'(INIT_LEN);
      r_grow_pend <= 1'b0;
      r_moved     <= 1'b0;
      r_self_hit  <= 1'b0;
      r_oob       <= 1'b0;
      r_head      <= 1'b0;
      r_body      <= 1'b0;
    end else begin
      if (w_go) begin
        r_seg[0] <= w_head_nx;
        for (int i = 1; i < MAX_LEN; i++) r_seg[i] <= r_seg[i-1];
        if (r_grow_pend || grow) r_len <= (r_len == 6'(MAX_LEN)) ? r_len : r_len + 6'd1;
      end
      r_grow_pend <= !w_go && (grow || r_grow_pend);
      r_moved     <= w_go;
      r_self_hit  <= r_self_hit | w_hit_set;
      r_oob       <= r_oob | w_edge_hit;
      r_head      <= w_pix_head;
      r_body      <= w_pix_body;
    end
  end

  assign snake_head    = r_head;
  assign snake_body    = r_body;
  assign snake_length  = r_len;
  assign head_x        = r_seg[0].x;
  assign head_y        = r_seg[0].y;
  assign self_hit      = r_self_hit;
  assign out_of_bounds = r_oob;
endmodule

// File: tb/tb_snake_segments.sv
// tb_snake_segments: directed table, corner sequences and random play against a queue-based snake model.
module tb_snake_segments;
  logic vga_clk = 1'b0, reset = 1'b0, move_tick = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic grow = 1'b0, freeze = 1'b0, restart = 1'b0;
  logic [11:0] pixel_row = 12'd0, pixel_col = 12'd0;
  logic snake_head, snake_body, self_hit, out_of_bounds;
  logic [5:0] snake_length, head_x;
  logic [4:0] head_y;
  int n_chk = 0, n_err = 0;

  // Model: directions 0=up 1=down 2=left 3=right; states 0=idle 1=run 2=frozen.
  int m_x[$], m_y[$];
  int m_len, m_state, m_dir, m_pend, m_gp, m_sh, m_oob, m_moved, m_head, m_body;

  typedef struct {
    int u, d, l, r, tk, gr, row, col, hx, hy, len, hd, bd;
  } vec_t;
  vec_t tbl[$];

  snake_segments dut (
    .vga_clk(vga_clk), .reset(reset), .move_tick(move_tick), .up(up), .down(down),
    .left(left), .right(right), .grow(grow), .freeze(freeze), .restart(restart),
    .pixel_row(pixel_row), .pixel_col(pixel_col), .snake_head(snake_head),
    .snake_body(snake_body), .snake_length(snake_length), .head_x(head_x),
    .head_y(head_y), .self_hit(self_hit), .out_of_bounds(out_of_bounds)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    m_x.delete();
    m_y.delete();
    for (int i = 0; i < 32; i++) begin
      m_x.push_back(i < 3 ? 20 - i : 0);
      m_y.push_back(15);
    end
    m_len = 3; m_state = 0; m_dir = 3; m_pend = 3;
    m_gp = 0; m_sh = 0; m_oob = 0; m_moved = 0; m_head = 0; m_body = 0;
  endtask

  task automatic model_update();
    int cx, cy, req, np, nd, nx, ny;
    bit in_r, eh, eb, hit, any, mv, out, moved;
    in_r = pixel_col < 640 && pixel_row < 480;
    cx = pixel_col / 16;
    cy = pixel_row / 16;
    eh = in_r && cx == m_x[0] && cy == m_y[0];
    eb = 0;
    for (int k = 1; k < m_len; k++) if (in_r && cx == m_x[k] && cy == m_y[k]) eb = 1;
    eb = eb && !eh;
    if (restart) begin
      model_reset();
      return;
    end
    hit = 0;
    if (m_moved != 0)
      for (int k = 1; k < m_len; k++) if (m_x[k] == m_x[0] && m_y[k] == m_y[0]) hit = 1;
    any = up | down | left | right;
    req = up ? 0 : down ? 1 : left ? 2 : 3;
    np = (any && req != opp(m_dir)) ? req : m_pend;
    mv = m_state == 1 && move_tick;
    nd = mv ? m_pend : m_dir;
    nx = m_x[0] + (m_pend == 3 ? 1 : m_pend == 2 ? -1 : 0);
    ny = m_y[0] + (m_pend == 1 ? 1 : m_pend == 0 ? -1 : 0);
    out = nx < 0 || nx >= 40 || ny < 0 || ny >= 30;
`ifdef SNAKE_WRAP_EN
    nx = (nx + 40) % 40;
    ny = (ny + 30) % 30;
    out = 0;
`endif
    moved = mv && !out;
    if (moved) begin
      m_x.push_front(nx);
      m_y.push_front(ny);
      void'(m_x.pop_back());
      void'(m_y.pop_back());
      if (m_gp != 0 || grow) begin
        if (m_len < 32) m_len++;
        m_gp = 0;
      end
    end else if (grow) m_gp = 1;
    if (mv && out) m_oob = 1;
    if (hit) m_sh = 1;
    if (m_state == 0) m_state = freeze ? 2 : any ? 1 : 0;
    else if (m_state == 1 && (freeze || m_sh != 0 || m_oob != 0)) m_state = 2;
    m_dir = nd; m_pend = np; m_moved = moved; m_head = eh; m_body = eb;
  endtask

  task automatic check_all();
    check("snake_head", snake_head, m_head);
    check("snake_body", snake_body, m_body);
    check("snake_length", snake_length, m_len);
    check("head_x", head_x, m_x[0]);
    check("head_y", head_y, m_y[0]);
    check("self_hit", self_hit, m_sh);
    check("out_of_bounds", out_of_bounds, m_oob);
  endtask

  task automatic drive(input int u, d, l, r, tk, gr, fz, rs, row, col);
    up = u != 0; down = d != 0; left = l != 0; right = r != 0;
    move_tick = tk != 0; grow = gr != 0; freeze = fz != 0; restart = rs != 0;
    pixel_row = 12'(row); pixel_col = 12'(col);
  endtask

  task automatic edge_check();
    model_update();
    @(posedge vga_clk);
    @(negedge vga_clk);
    check_all();
  endtask

  task automatic cyc(input int u, d, l, r, tk, gr, fz, rs);
    drive(u, d, l, r, tk, gr, fz, rs, 0, 0);
    edge_check();
  endtask

  function automatic vec_t mk(input int u, d, l, r, tk, gr, row, col, hx, hy, len, hd, bd);
    vec_t v;
    v = '{u, d, l, r, tk, gr, row, col, hx, hy, len, hd, bd};
    return v;
  endfunction

  initial begin
    tbl.push_back(mk(0,0,0,1,0,0,   0,   0, 20,15,3,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,   0,   0, 21,15,3,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,   0,   0, 22,15,3,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,   0,   0, 23,15,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 240, 368, 23,15,3,1,0));
    tbl.push_back(mk(0,0,1,0,0,0,   0,   0, 23,15,3,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,   0,   0, 24,15,3,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,   0,   0, 24,15,3,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,   0,   0, 24,14,3,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,   0,   0, 24,13,4,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,   0,   0, 24,13,4,0,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,0,0,0, 0, 0, 24,13,4,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,   0,   0, 24,12,5,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 211, 389, 24,12,5,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 100, 700, 24,12,5,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 207, 399, 24,12,5,1,0));

    model_reset();
    repeat (2) @(negedge vga_clk);
    check_all();
    check("rst_len", snake_length, 3);
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].tk, tbl[i].gr, 0, 0, tbl[i].row, tbl[i].col);
      edge_check();
      check("tbl_hx", head_x, tbl[i].hx);
      check("tbl_hy", head_y, tbl[i].hy);
      check("tbl_len", snake_length, tbl[i].len);
      check("tbl_head", snake_head, tbl[i].hd);
      check("tbl_body", snake_body, tbl[i].bd);
    end

    // U-turn into own tail: right, down, left with length 5.
    cyc(0,0,0,1,0,0,0,0);
    cyc(0,0,0,0,1,0,0,0);
    cyc(0,1,0,0,0,0,0,0);
    cyc(0,0,0,0,1,0,0,0);
    cyc(0,0,1,0,0,0,0,0);
    cyc(0,0,0,0,1,0,0,0);
    check("sh_not_yet", self_hit, 0);
    check("sh_move_x", head_x, 24);
    cyc(0,0,0,0,0,0,0,0);
    check("sh_set", self_hit, 1);
    cyc(0,0,0,0,1,0,0,0);
    cyc(0,0,0,0,1,0,0,0);
    check("frozen_hx", head_x, 24);
    check("frozen_hy", head_y, 13);

    cyc(0,0,0,0,0,0,0,1);
    check("restart_hx", head_x, 20);
    check("restart_len", snake_length, 3);
    check("restart_sh", self_hit, 0);

    cyc(0,0,0,1,0,0,0,0);
    for (int i = 0; i < 19; i++) cyc(0,0,0,0,1,0,0,0);
    check("edge_pre_hx", head_x, 39);
    cyc(0,0,0,0,1,0,0,0);
`ifdef SNAKE_WRAP_EN
    check("wrap_hx", head_x, 0);
    check("wrap_oob", out_of_bounds, 0);
`else
    check("edge_hx", head_x, 39);
    check("edge_oob", out_of_bounds, 1);
    cyc(0,0,0,0,1,0,0,0);
    check("edge_frozen_hx", head_x, 39);
`endif
    cyc(0,0,0,0,0,0,0,1);

    // Asynchronous reset in the middle of a move tick.
    cyc(0,0,0,1,0,0,0,0);
    cyc(0,0,0,0,1,1,0,0);
    drive(0,0,0,0,1,0,0,0,240,336);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_all();
    check("arst_hx", head_x, 20);
    check("arst_len", snake_length, 3);
    reset = 1'b1;
    drive(0,0,0,0,0,0,0,0,0,0);
    edge_check();

    for (int n = 0; n < 3000; n++) begin
      int u, d, l, r, row, col, k;
      u = 0; d = 0; l = 0; r = 0;
      if ($urandom_range(3) == 0) begin
        u = $urandom_range(1); d = $urandom_range(1); l = $urandom_range(1); r = $urandom_range(1);
      end
      if ($urandom_range(1) == 0) begin
        k = $urandom_range(m_len - 1);
        col = m_x[k] * 16 + $urandom_range(15);
        row = m_y[k] * 16 + $urandom_range(15);
      end else begin
        col = $urandom_range(799);
        row = $urandom_range(524);
      end
      drive(u, d, l, r, $urandom_range(2) == 0, $urandom_range(15) == 0, $urandom_range(299) == 0,
            $urandom_range(199) == 0 || (m_state == 2 && $urandom_range(19) == 0), row, col);
      edge_check();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
